// File: rtl/wb_rr_sharedbus_if.sv
// Wishbone pipelined bundle for N endpoints; the master modport is the
// view of the initiating devices, the slave modport the view of the responders.
interface wb_rr_sharedbus_if #(parameter int N = 1);
  logic [N-1:0]       cyc, stb, we;
  logic [N-1:0][29:0] adr;
  logic [N-1:0][31:0] dat_m;
  logic [N-1:0][3:0]  sel;
  logic [N-1:0]       stall, ack, err;
  logic [N-1:0][31:0] dat_s;

  modport master (output cyc, stb, we, adr, dat_m, sel, input stall, ack, err, dat_s);
  modport slave  (input cyc, stb, we, adr, dat_m, sel, output stall, ack, err, dat_s);
endinterface

// File: rtl/wb_rr_sharedbus.sv
// Round-robin shared Wishbone bus: one owner at a time, address-decoded slaves,
// outstanding-strobe tracking with slave lock, unmapped-address error and response timeout.
module wb_rr_sharedbus #(
  parameter int                     NUMM            = 3,
  parameter int                     NUMS            = 9,
  parameter logic [NUMS-1:0][31:0]  BASE_ADDR       = '0,
  parameter logic [NUMS-1:0][31:0]  SIZE            = {NUMS{32'h10}},
  parameter int                     MAX_OUTSTANDING = 4,
  parameter int                     TIMEOUT         = 1023
) (
  input  logic              clk,
  input  logic              rst,
  wb_rr_sharedbus_if.slave  wbm,
  wb_rr_sharedbus_if.master wbs,
  output logic [NUMM-1:0]   grant_o,
  output logic              timeout_o
);
  localparam int MW = (NUMM > 1) ? $clog2(NUMM) : 1;
  localparam int SW = (NUMS > 1) ? $clog2(NUMS) : 1;
  localparam logic [3:0]  CMAX     = 4'(MAX_OUTSTANDING);
  localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;

  logic [1:0]    state;
  logic [MW-1:0] owner, rr_ptr, pick, nxt_ptr;
  logic [3:0]    cnt, cnt_nxt;
  logic          lock_vld, err_pend;
  logic [SW-1:0] lock_idx, dec_idx;
  logic          dec_vld;
  logic [31:0]   tmo_cnt;

  logic          o_cyc, o_stb, o_we;
  logic [29:0]   o_adr;
  logic [31:0]   o_dat;
  logic [3:0]    o_sel;
  logic          run, s_ack, s_err, m_ack, m_err, rsp, tmo_hit;
  logic          mismatch, hold, o_stall, fwd, accept;

  function automatic logic [MW-1:0] rr_pick(input logic [NUMM-1:0] req, input logic [MW-1:0] ptr);
    logic [MW-1:0] r;
    logic          found;
    int            k;
    r = '0;
    found = 1'b0;
    for (int j = 0; j < NUMM; j++) begin
      k = int'(ptr) + j;
      if (k >= NUMM) k = k - NUMM;
      if (!found && req[k]) begin
        found = 1'b1;
        r = MW'(k);
      end
    end
    return r;
  endfunction

  assign pick    = rr_pick(wbm.cyc, rr_ptr);
  assign nxt_ptr = (owner == MW'(NUMM - 1)) ? '0 : owner + MW'(1);

  assign o_cyc = wbm.cyc[owner];
  assign o_stb = wbm.stb[owner];
  assign o_we  = wbm.we[owner];
  assign o_adr = wbm.adr[owner];
  assign o_dat = wbm.dat_m[owner];
  assign o_sel = wbm.sel[owner];

  // Descending scan so the lowest matching slave index wins on overlap.
  always_comb begin
    dec_vld = 1'b0;
    dec_idx = '0;
    for (int k = NUMS - 1; k >= 0; k--)
      if (({o_adr, 2'b00} & ~(SIZE[k] - 32'd1)) == BASE_ADDR[k]) begin
        dec_vld = 1'b1;
        dec_idx = SW'(k);
      end
  end

  assign run   = (state == BUSY) & o_cyc & ~rst;
  assign s_ack = lock_vld & wbs.ack[lock_idx];
  assign s_err = lock_vld & wbs.err[lock_idx];
  assign m_err = run & (s_err | err_pend);
  assign m_ack = run & s_ack & ~s_err;
  assign rsp   = m_ack | m_err;

  assign tmo_hit = (TIMEOUT != 0) & run & (cnt != 4'd0) & ~rsp & (tmo_cnt == TMO_LAST);

  // Keep responses in order: with anything in flight only the locked slave may take more.
  assign mismatch = (cnt != 4'd0) & (~dec_vld | ~lock_vld | (dec_idx != lock_idx));
  assign hold     = (cnt == CMAX) | mismatch | tmo_hit;
  assign fwd      = run & o_stb & dec_vld & ~hold;
  assign o_stall  = hold | (dec_vld & wbs.stall[dec_idx]);
  assign accept   = run & o_stb & ~o_stall;
  assign cnt_nxt  = cnt + {3'b000, accept} - {3'b000, rsp};

  always_comb begin
    for (int i = 0; i < NUMM; i++) begin
      wbm.stall[i] = 1'b1;
      wbm.ack[i]   = 1'b0;
      wbm.err[i]   = 1'b0;
      wbm.dat_s[i] = '0;
      if (state == BUSY && owner == MW'(i)) begin
        wbm.stall[i] = ~run | o_stall;
        wbm.ack[i]   = m_ack;
        wbm.err[i]   = m_err | tmo_hit;
        wbm.dat_s[i] = lock_vld ? wbs.dat_s[lock_idx] : '0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUMS; k++) begin
      wbs.cyc[k]   = run & (lock_vld ? (lock_idx == SW'(k)) : (dec_vld & (dec_idx == SW'(k))));
      wbs.stb[k]   = fwd & (dec_idx == SW'(k));
      wbs.we[k]    = o_we;
      wbs.adr[k]   = o_adr;
      wbs.dat_m[k] = o_dat;
      wbs.sel[k]   = o_sel;
    end
  end

  always_comb begin
    grant_o = '0;
    if (state != IDLE) grant_o[owner] = 1'b1;
  end

  assign timeout_o = tmo_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      cnt      <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      err_pend <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      err_pend <= 1'b0;
      case (state)
        IDLE: begin
          cnt      <= '0;
          lock_vld <= 1'b0;
          tmo_cnt  <= '0;
          if (|wbm.cyc) begin
            owner <= pick;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (!o_cyc) begin
            state    <= IDLE;
            rr_ptr   <= nxt_ptr;
            cnt      <= '0;
            lock_vld <= 1'b0;
            tmo_cnt  <= '0;
          end else if (tmo_hit) begin
            state    <= ABORT;
            cnt      <= '0;
            lock_vld <= 1'b0;
            tmo_cnt  <= '0;
          end else begin
            cnt      <= cnt_nxt;
            err_pend <= accept & ~dec_vld;
            if (accept && dec_vld) begin
              lock_vld <= 1'b1;
              lock_idx <= dec_idx;
            end else if (cnt_nxt == 4'd0) begin
              lock_vld <= 1'b0;
            end
            tmo_cnt <= (cnt != 4'd0 && !rsp && TIMEOUT != 0) ? tmo_cnt + 32'd1 : '0;
          end
        end
        ABORT: begin
          if (!o_cyc) begin
            state  <= IDLE;
            rr_ptr <= nxt_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
